// File: rtl/gpio_bus_initiator.sv
// Single-command initiator for the 32-bit peripheral bus: read, write and
// read-modify-write (set/clear bits), one registered response per command.
module gpio_bus_initiator #(
    parameter int READ_LATENCY = 1,
    parameter int DATA_W       = 32
) (
    input  logic              CoreClock,
    input  logic              Reset,
    input  logic              CmdValid,
    output logic              CmdReady,
    input  logic [1:0]        CmdOp,
    input  logic [31:0]       CmdAddress,
    input  logic [DATA_W-1:0] CmdData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] RspData,
    output logic              Busy,
    output logic [31:0]       AddressBus,
    output logic [DATA_W-1:0] DataWriteBus,
    output logic              WriteAssert,
    input  logic [DATA_W-1:0] DataReadBus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [31:0]         abus_q, abus_d;
    logic [DATA_W-1:0]   wbus_q, wbus_d;
    logic                we_q, we_d;
    logic                rsp_vld_q;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

    // Op bit 0 selects clear (rd & ~mask) over set (rd | mask).
    function automatic logic [DATA_W-1:0] rmw_merge(input logic [1:0]        op,
                                                    input logic [DATA_W-1:0] rd,
                                                    input logic [DATA_W-1:0] mask);
        return op[0] ? (rd & ~mask) : (rd | mask);
    endfunction

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        abus_d     = abus_q;
        wbus_d     = wbus_q;
        we_d       = 1'b0;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (CmdValid) begin
                    op_d   = CmdOp;
                    data_d = CmdData;
                    abus_d = CmdAddress;
                    if (CmdOp == OP_WRITE) begin
                        wbus_d  = CmdData;
                        we_d    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    rd_d = DataReadBus;
                    if (op_q == OP_READ) begin
                        rsp_data_d = DataReadBus;
                        state_d    = RESP;
                    end else begin
                        data_d  = rmw_merge(op_q, DataReadBus, data_q);
                        wbus_d  = rmw_merge(op_q, DataReadBus, data_q);
                        we_d    = 1'b1;
                        state_d = WRITE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                rsp_data_d = data_q;
                state_d    = RESP;
            end
            RESP: begin
                if (RspReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered bus/response outputs
    always_ff @(posedge CoreClock) begin
        if (Reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            data_q     <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            abus_q     <= '0;
            wbus_q     <= '0;
            we_q       <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            abus_q     <= abus_d;
            wbus_q     <= wbus_d;
            we_q       <= we_d;
            rsp_vld_q  <= (state_d == RESP);
            rsp_data_q <= rsp_data_d;
        end
    end

    assign CmdReady     = (state_q == IDLE);
    assign Busy         = (state_q != IDLE);
    assign RspValid     = rsp_vld_q;
    assign RspData      = rsp_data_q;
    assign AddressBus   = abus_q;
    assign DataWriteBus = wbus_q;
    assign WriteAssert  = we_q;

endmodule
